tour_sel_ctrl: RTL and testbench
================================

Name: tour_sel_ctrl

Overview:
- Controller for the tournament-selection phase of the GA core (CONDUCT_TOUR state).
- On start, runs 2*NUM_PAIRS tournaments over the population register file. Each tournament draws TOUR_SIZE random candidate indices from the LFSR bank, reads their fitness and keeps the minimum.
- Emits parent index pairs to the crossover stage over a valid/ready handshake, then pulses done so the top FSM can advance.

Parameters:
- POP_SIZE, 40, population entries in pop_rf.
- IDX_WIDTH, 6, index width; POP_SIZE must satisfy 2^(IDX_WIDTH-1) < POP_SIZE <= 2^IDX_WIDTH.
- IND_FIT_LENGTH, 10, fitness width (unsigned; lower is better).
- RAND_WIDTH, 8, LFSR output width (>= IDX_WIDTH).
- TOUR_SIZE, 3, candidates per tournament (>= 2).
- NUM_PAIRS, 20, parent pairs per generation.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start_i  in  1  one-cycle request to begin a selection round; honoured only in IDLE.
- rand_i  in  RAND_WIDTH  free-running LFSR value; sampled on every cycle rd_en_o=1.
- rd_en_o  out  1  fitness read strobe to pop_rf.
- rd_idx_o  out  IDX_WIDTH  candidate index being read.
- rd_fit_i  in  IND_FIT_LENGTH  fitness of rd_idx_o, valid exactly 1 cycle after rd_en_o.
- pair_valid_o  out  1  parent pair available.
- pair_ready_i  in  1  crossover stage accepts the pair.
- parent_a_o  out  IDX_WIDTH  first parent index.
- parent_b_o  out  IDX_WIDTH  second parent index.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse after the last pair is accepted.

Behaviour:
- Reset (async, any time, including mid-round):
  - state=IDLE; all outputs 0.
  - pair counter, candidate counter and best-fitness register cleared.
  - An in-flight round is abandoned; there is no resume.
- Index mapping: r = rand_i[IDX_WIDTH-1:0]; rd_idx_o = r if r < POP_SIZE, else r - POP_SIZE. rd_idx_o is combinational from rand_i while rd_en_o=1 and is 0 otherwise.
- FSM states: IDLE, SAMPLE_A, DRAIN_A, SAMPLE_B, DRAIN_B, OFFER, DONE.
  - IDLE -> SAMPLE_A on start_i.
  - SAMPLE_x: rd_en_o=1 for TOUR_SIZE consecutive cycles, candidate counter 0..TOUR_SIZE-1; -> DRAIN_x after the last read.
  - DRAIN_x: 1 cycle, consumes the last fitness and latches the winner index into parent_a_o or parent_b_o.
  - DRAIN_A -> SAMPLE_B.
  - DRAIN_B -> OFFER.
  - OFFER: pair_valid_o=1; parent_a_o and parent_b_o held stable until pair_valid_o & pair_ready_i.
    - On transfer: pair counter +1. If the count reaches NUM_PAIRS -> DONE, else -> SAMPLE_A.
    - pair_valid_o drops in the cycle after the transfer.
  - DONE: done_o=1 for 1 cycle; -> IDLE.
- Comparison:
  - The first candidate loads best_fit/best_idx unconditionally.
  - Later candidates replace it only on strictly less fitness, so on a tie the earliest-sampled candidate wins.
  - Duplicate candidate indices within one tournament are allowed.
- Latency: start_i at cycle 0 -> first rd_en_o at cycle 1 -> first pair_valid_o at cycle 2*(TOUR_SIZE+1)+1 (= 9 by default).
  - With pair_ready_i tied high, each pair takes 2*(TOUR_SIZE+1)+1 cycles.
  - A full round takes NUM_PAIRS*9 + 2 cycles from start to done_o (default).
- Boundary conditions:
  - start_i while busy_o=1 is ignored.
  - start_i in the DONE cycle is ignored.
  - pair_ready_i outside OFFER is ignored.
  - The counter width holds NUM_PAIRS with no wrap; the counter clears on entry to IDLE.

Optional Feature:
- Macro: TOUR_DISTINCT_PARENT_EN.
- Defined: in DRAIN_B, if the B winner equals parent_a_o, tournament B reruns (-> SAMPLE_B) instead of going to OFFER. Up to 3 reruns per pair; the 4th result is accepted even if equal.
- Undefined: no check; identical parents are allowed.

Test Plan:
- Reset mid-SAMPLE_B (rst pulse at cycle 6) -> all outputs 0 next cycle, state IDLE, busy_o=0; a later start_i runs a fresh round from pair 0.
- fit[i]=100+i, rand_i sequence 5,12,47,30,2,63 (47->7, 63->23), pair_ready_i=1 -> rd_idx_o reads 5,12,7 then 30,2,23; first pair at cycle 9 is parent_a_o=5, parent_b_o=2.
- Tie: fit[3]=fit[9]=10, all other fitness values 500, rand_i 9,3,20 -> winner 9 (earliest sampled).
- Backpressure: pair_ready_i held 0 for 5 cycles in OFFER -> pair_valid_o, parent_a_o and parent_b_o stable; no rd_en_o; transfer on the 6th cycle; rd_en_o resumes the next cycle.
- Full round, NUM_PAIRS=20, ready=1 -> exactly 20 transfers; done_o single pulse at cycle 182; start_i during the round ignored (no extra pairs).
- TOUR_DISTINCT_PARENT_EN defined: rand_i forces B winner = A winner twice, then differs -> two reruns (pair at cycle 17), parents distinct. Without the macro, the same stimulus gives the pair at cycle 9 with equal parents.

Source files
------------

// File: rtl/tour_sel_if.sv
// Bus between tour_sel_ctrl and its neighbours: the LFSR source, the pop_rf fitness
// read port and the parent-pair handshake to crossover. master = controller side.
interface tour_sel_if #(
  parameter int IDX_WIDTH      = 6,
  parameter int IND_FIT_LENGTH = 10,
  parameter int RAND_WIDTH     = 8
);
  logic                      start_i;
  logic [RAND_WIDTH-1:0]     rand_i;
  logic                      rd_en_o;
  logic [IDX_WIDTH-1:0]      rd_idx_o;
  logic [IND_FIT_LENGTH-1:0] rd_fit_i;
  logic                      pair_valid_o;
  logic                      pair_ready_i;
  logic [IDX_WIDTH-1:0]      parent_a_o;
  logic [IDX_WIDTH-1:0]      parent_b_o;
  logic                      busy_o;
  logic                      done_o;

  modport master (
    input  start_i, rand_i, rd_fit_i, pair_ready_i,
    output rd_en_o, rd_idx_o, pair_valid_o, parent_a_o, parent_b_o, busy_o, done_o
  );

  modport slave (
    output start_i, rand_i, rd_fit_i, pair_ready_i,
    input  rd_en_o, rd_idx_o, pair_valid_o, parent_a_o, parent_b_o, busy_o, done_o
  );
endinterface

// File: rtl/tour_sel_ctrl.sv
// Tournament-selection controller: 2*NUM_PAIRS min-fitness tournaments, parent pairs out
// over valid/ready, then a done pulse. Optional macro TOUR_DISTINCT_PARENT_EN reruns B on A==B.
module tour_sel_ctrl #(
  parameter int POP_SIZE       = 40,
  parameter int IDX_WIDTH      = 6,
  parameter int IND_FIT_LENGTH = 10,
  parameter int RAND_WIDTH     = 8,
  parameter int TOUR_SIZE      = 3,
  parameter int NUM_PAIRS      = 20
) (
  input  logic       clk,
  input  logic       rst,
  tour_sel_if.master bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SAMPLE_A = 3'd1;
  localparam logic [2:0] S_DRAIN_A  = 3'd2;
  localparam logic [2:0] S_SAMPLE_B = 3'd3;
  localparam logic [2:0] S_DRAIN_B  = 3'd4;
  localparam logic [2:0] S_OFFER    = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  localparam int CAND_W = $clog2(TOUR_SIZE);
  localparam int PAIR_W = $clog2(NUM_PAIRS + 1);

  localparam logic [CAND_W-1:0]    CAND_LAST  = CAND_W'(TOUR_SIZE - 1);
  localparam logic [PAIR_W-1:0]    PAIR_FINAL = PAIR_W'(NUM_PAIRS - 1);
  localparam logic [IDX_WIDTH:0]   POP_LIM    = (IDX_WIDTH + 1)'(POP_SIZE);
  localparam logic [IDX_WIDTH-1:0] POP_LOW    = IDX_WIDTH'(POP_SIZE);

  logic [2:0]                state_q, state_d;
  logic [CAND_W-1:0]         cand_q, cand_d;
  logic [PAIR_W-1:0]         pair_q, pair_d;
  logic [IND_FIT_LENGTH-1:0] best_fit_q, best_fit_d;
  logic [IDX_WIDTH-1:0]      best_idx_q, best_idx_d;
  logic                      cmp_vld_q, cmp_vld_d;
  logic                      cmp_first_q, cmp_first_d;
  logic [IDX_WIDTH-1:0]      cmp_idx_q, cmp_idx_d;
  logic [IDX_WIDTH-1:0]      par_a_q, par_a_d;
  logic [IDX_WIDTH-1:0]      par_b_q, par_b_d;
  logic                      done_q, done_d;
`ifdef TOUR_DISTINCT_PARENT_EN
  logic [1:0]                rerun_q, rerun_d;
`endif

  logic                 rd_en;
  logic [IDX_WIDTH-1:0] rand_low;
  logic [IDX_WIDTH:0]   rand_ext;
  logic [IDX_WIDTH-1:0] mapped_idx;
  logic [IDX_WIDTH-1:0] rd_idx;
  logic                 take;
  logic [IDX_WIDTH-1:0] win_idx;
  logic                 xfer;

  // Only the low IDX_WIDTH LFSR bits select a candidate.
  generate
    if (RAND_WIDTH > IDX_WIDTH) begin : g_rand_hi
      logic unused_rand_hi;
      assign unused_rand_hi = ^bus.rand_i[RAND_WIDTH-1:IDX_WIDTH];
    end
  endgenerate

  assign rand_low = bus.rand_i[IDX_WIDTH-1:0];
  assign rand_ext = {1'b0, rand_low};

  // Out-of-range draws fold back by one POP_SIZE; the modular subtract is exact there.
  always_comb begin
    mapped_idx = rand_low;
    if (rand_ext >= POP_LIM) begin
      mapped_idx = rand_low - POP_LOW;
    end
  end

  assign rd_en  = (state_q == S_SAMPLE_A) || (state_q == S_SAMPLE_B);
  assign rd_idx = rd_en ? mapped_idx : '0;

  // Fitness for the candidate issued last cycle is on rd_fit_i now.
  assign take    = cmp_vld_q && (cmp_first_q || (bus.rd_fit_i < best_fit_q));
  assign win_idx = take ? cmp_idx_q : best_idx_q;
  assign xfer    = (state_q == S_OFFER) && bus.pair_ready_i;

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    pair_d      = pair_q;
    best_fit_d  = best_fit_q;
    best_idx_d  = best_idx_q;
    par_a_d     = par_a_q;
    par_b_d     = par_b_q;
    cmp_vld_d   = rd_en;
    cmp_first_d = rd_en && (cand_q == '0);
    cmp_idx_d   = rd_idx;
    done_d      = (state_q == S_DONE);
`ifdef TOUR_DISTINCT_PARENT_EN
    rerun_d     = rerun_q;
`endif

    if (take) begin
      best_fit_d = bus.rd_fit_i;
      best_idx_d = cmp_idx_q;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          state_d = S_SAMPLE_A;
          cand_d  = '0;
          pair_d  = '0;
        end
      end
      S_SAMPLE_A: begin
        if (cand_q == CAND_LAST) begin
          cand_d  = '0;
          state_d = S_DRAIN_A;
        end else begin
          cand_d = cand_q + 1'b1;
        end
      end
      S_DRAIN_A: begin
        par_a_d = win_idx;
        state_d = S_SAMPLE_B;
`ifdef TOUR_DISTINCT_PARENT_EN
        rerun_d = '0;
`endif
      end
      S_SAMPLE_B: begin
        if (cand_q == CAND_LAST) begin
          cand_d  = '0;
          state_d = S_DRAIN_B;
        end else begin
          cand_d = cand_q + 1'b1;
        end
      end
      S_DRAIN_B: begin
        par_b_d = win_idx;
        state_d = S_OFFER;
`ifdef TOUR_DISTINCT_PARENT_EN
        // Three reruns at most; the fourth B result stands even if it matches A.
        if ((win_idx == par_a_q) && (rerun_q != 2'd3)) begin
          rerun_d = rerun_q + 2'd1;
          state_d = S_SAMPLE_B;
        end
`endif
      end
      S_OFFER: begin
        if (xfer) begin
          pair_d  = pair_q + 1'b1;
          state_d = (pair_q == PAIR_FINAL) ? S_DONE : S_SAMPLE_A;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        pair_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        pair_d  = '0;
        cand_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cand_q      <= '0;
      pair_q      <= '0;
      best_fit_q  <= '0;
      best_idx_q  <= '0;
      cmp_vld_q   <= 1'b0;
      cmp_first_q <= 1'b0;
      cmp_idx_q   <= '0;
      par_a_q     <= '0;
      par_b_q     <= '0;
      done_q      <= 1'b0;
`ifdef TOUR_DISTINCT_PARENT_EN
      rerun_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      pair_q      <= pair_d;
      best_fit_q  <= best_fit_d;
      best_idx_q  <= best_idx_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_first_q <= cmp_first_d;
      cmp_idx_q   <= cmp_idx_d;
      par_a_q     <= par_a_d;
      par_b_q     <= par_b_d;
      done_q      <= done_d;
`ifdef TOUR_DISTINCT_PARENT_EN
      rerun_q     <= rerun_d;
`endif
    end
  end

  assign bus.rd_en_o      = rd_en;
  assign bus.rd_idx_o     = rd_idx;
  assign bus.pair_valid_o = (state_q == S_OFFER);
  assign bus.parent_a_o   = par_a_q;
  assign bus.parent_b_o   = par_b_q;
  assign bus.busy_o       = (state_q != S_IDLE);
  assign bus.done_o       = done_q;

endmodule

// File: tb/tb_tour_sel_ctrl.sv
// Bench for tour_sel_ctrl: pop_rf fitness model, LFSR stimulus queue and a
// tournament model feeding an expected-pair scoreboard checked at each transfer.
module tb_tour_sel_ctrl;
  localparam int POP    = 40;
  localparam int IDX_W  = 6;
  localparam int FIT_W  = 10;
  localparam int RAND_W = 8;
  localparam int TOUR   = 3;
  localparam int NPAIR  = 20;

  typedef struct {
    int a;
    int b;
  } pair_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tour_sel_if #(.IDX_WIDTH(IDX_W), .IND_FIT_LENGTH(FIT_W), .RAND_WIDTH(RAND_W)) bus();

  tour_sel_ctrl #(
    .POP_SIZE(POP), .IDX_WIDTH(IDX_W), .IND_FIT_LENGTH(FIT_W),
    .RAND_WIDTH(RAND_W), .TOUR_SIZE(TOUR), .NUM_PAIRS(NPAIR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rq[$];
  pair_t exp_q[$];
  logic [FIT_W-1:0] fit_mem [64];

  // pop_rf: fitness of the strobed index one cycle later, noise otherwise.
  always @(posedge clk) begin
    if (bus.rd_en_o) bus.rd_fit_i <= fit_mem[bus.rd_idx_o];
    else             bus.rd_fit_i <= FIT_W'($urandom);
  end

  function automatic int map_idx(int r);
    int v;
    v = r % (1 << IDX_W);
    return (v < POP) ? v : v - POP;
  endfunction

  int    m_idx, m_draws, m_bfit, m_bidx, m_a, m_reruns;
  bit    m_have_a;
  pair_t m_tmp, m_exp;

  always @(negedge clk) begin
    if (rst) begin
      m_draws = 0; m_have_a = 0; m_reruns = 0;
      exp_q.delete();
    end else begin
      if (bus.rd_en_o) begin
        m_idx = map_idx(int'(bus.rand_i));
        checks++;
        if (bus.rd_idx_o !== IDX_W'(m_idx)) begin
          errors++;
          $display("FAIL rd_idx cyc %0d: got %0d want %0d", cyc, bus.rd_idx_o, m_idx);
        end
        if (m_draws == 0 || int'(fit_mem[m_idx]) < m_bfit) begin
          m_bfit = int'(fit_mem[m_idx]);
          m_bidx = m_idx;
        end
        m_draws++;
        if (m_draws == TOUR) begin
          m_draws = 0;
          if (!m_have_a) begin
            m_a = m_bidx; m_have_a = 1;
          end else begin
`ifdef TOUR_DISTINCT_PARENT_EN
            if (m_bidx == m_a && m_reruns < 3) begin
              m_reruns++;
            end else begin
              m_tmp.a = m_a; m_tmp.b = m_bidx; exp_q.push_back(m_tmp);
              m_have_a = 0; m_reruns = 0;
            end
`else
            m_tmp.a = m_a; m_tmp.b = m_bidx; exp_q.push_back(m_tmp);
            m_have_a = 0;
`endif
          end
        end
      end else begin
        checks++;
        if (bus.rd_idx_o !== '0) begin
          errors++;
          $display("FAIL rd_idx_idle cyc %0d: got %0d want 0", cyc, bus.rd_idx_o);
        end
      end
      if (bus.pair_valid_o && bus.pair_ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pair_unexpected cyc %0d: got %0d/%0d, none expected", cyc, bus.parent_a_o, bus.parent_b_o);
        end else begin
          m_exp = exp_q.pop_front();
          if (bus.parent_a_o !== IDX_W'(m_exp.a) || bus.parent_b_o !== IDX_W'(m_exp.b)) begin
            errors++;
            $display("FAIL pair_sb cyc %0d: got %0d/%0d want %0d/%0d", cyc, bus.parent_a_o, bus.parent_b_o, m_exp.a, m_exp.b);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.rd_en_o && rq.size() > 0) bus.rand_i = RAND_W'(rq.pop_front());
    else                              bus.rand_i = RAND_W'($urandom_range(0, (1 << RAND_W) - 1));
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.pair_ready_i = 1'b1;
    rq.delete();
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic start_round();
    bus.start_i = 1'b1;
    cyc = 0;
    step();
    bus.start_i = 1'b0;
  endtask

  task automatic set_fit_linear();
    for (int i = 0; i < 64; i++) fit_mem[i] = FIT_W'(100 + i);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.rd_en_o, bus.rd_idx_o, bus.pair_valid_o, bus.parent_a_o, bus.parent_b_o, bus.busy_o, bus.done_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy %b valid %b rd_en %b pa %0d pb %0d, want all 0",
               bus.busy_o, bus.pair_valid_o, bus.rd_en_o, bus.parent_a_o, bus.parent_b_o);
    end
  endtask

  task automatic test_reset_mid();
    set_fit_linear();
    do_reset();
    start_round();
    while (cyc < 6) step();
    checks++;
    if (bus.busy_o !== 1'b1 || bus.rd_en_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: busy %b rd_en %b want 1 1", bus.busy_o, bus.rd_en_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.rd_en_o, bus.rd_idx_o, bus.pair_valid_o, bus.parent_a_o, bus.parent_b_o, bus.busy_o, bus.done_o} !== '0) begin
      errors++;
      $display("FAIL mid_reset_async: busy %b rd_en %b pa %0d, want all 0", bus.busy_o, bus.rd_en_o, bus.parent_a_o);
    end
    step();
    rst = 1'b0;
    step();
    step();
    checks++;
    if (bus.busy_o !== 1'b0 || bus.rd_en_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_idle: busy %b rd_en %b want 0 0", bus.busy_o, bus.rd_en_o);
    end
  endtask

  task automatic test_basic();
    int exp_c[6];
    int exp_i[6];
    int n;
    exp_c = '{1, 2, 3, 5, 6, 7};
    exp_i = '{5, 12, 7, 30, 2, 23};
    n = 0;
    set_fit_linear();
    do_reset();
    rq = '{5, 12, 47, 30, 2, 63};
    start_round();
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) step();
      if (bus.rd_en_o) begin
        if (n < 6) begin
          checks++;
          if (cyc != exp_c[n] || bus.rd_idx_o !== IDX_W'(exp_i[n])) begin
            errors++;
            $display("FAIL basic_read%0d: got idx %0d at cyc %0d want %0d at cyc %0d", n, bus.rd_idx_o, cyc, exp_i[n], exp_c[n]);
          end
        end
        n++;
      end
      if (c < 9) begin
        checks++;
        if (bus.pair_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL basic_early_valid: valid at cyc %0d", cyc);
        end
      end
    end
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL basic_read_count: got %0d want 6", n);
    end
    checks++;
    if (bus.pair_valid_o !== 1'b1 || bus.parent_a_o !== 6'd5 || bus.parent_b_o !== 6'd2) begin
      errors++;
      $display("FAIL basic_pair: valid %b a %0d b %0d at cyc %0d want 1 5 2 at 9", bus.pair_valid_o, bus.parent_a_o, bus.parent_b_o, cyc);
    end
  endtask

  task automatic test_tie();
    for (int i = 0; i < 64; i++) fit_mem[i] = FIT_W'(500);
    fit_mem[3] = FIT_W'(10);
    fit_mem[9] = FIT_W'(10);
    do_reset();
    rq = '{9, 3, 20, 20, 21, 22};
    start_round();
    while (cyc < 9) step();
    checks++;
    if (bus.pair_valid_o !== 1'b1 || bus.parent_a_o !== 6'd9 || bus.parent_b_o !== 6'd20) begin
      errors++;
      $display("FAIL tie_pair: valid %b a %0d b %0d want 1 9 20", bus.pair_valid_o, bus.parent_a_o, bus.parent_b_o);
    end
  endtask

  task automatic test_backpressure();
    logic [IDX_W-1:0] snap_a, snap_b;
    set_fit_linear();
    do_reset();
    bus.pair_ready_i = 1'b0;
    start_round();
    while (cyc < 9) step();
    snap_a = bus.parent_a_o;
    snap_b = bus.parent_b_o;
    for (int c = 9; c <= 13; c++) begin
      checks++;
      if (bus.pair_valid_o !== 1'b1 || bus.rd_en_o !== 1'b0 || bus.parent_a_o !== snap_a || bus.parent_b_o !== snap_b) begin
        errors++;
        $display("FAIL bp_hold cyc %0d: valid %b rd_en %b a %0d b %0d want 1 0 %0d %0d",
                 cyc, bus.pair_valid_o, bus.rd_en_o, bus.parent_a_o, bus.parent_b_o, snap_a, snap_b);
      end
      step();
    end
    bus.pair_ready_i = 1'b1;
    checks++;
    if (bus.pair_valid_o !== 1'b1 || cyc != 14) begin
      errors++;
      $display("FAIL bp_xfer: valid %b at cyc %0d want 1 at 14", bus.pair_valid_o, cyc);
    end
    step();
    checks++;
    if (bus.rd_en_o !== 1'b1 || bus.pair_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_resume: rd_en %b valid %b want 1 0", bus.rd_en_o, bus.pair_valid_o);
    end
    step();
  endtask

  task automatic test_full_round();
    int xfers, done_cnt, done_cyc, idle_viol;
    xfers = 0; done_cnt = 0; done_cyc = -1; idle_viol = 0;
    for (int i = 0; i < 64; i++) fit_mem[i] = FIT_W'($urandom_range(0, 1023));
    do_reset();
    start_round();
    while (cyc <= 190) begin
      bus.start_i = (cyc == 50 || cyc == 181);
      if (bus.pair_valid_o && bus.pair_ready_i) xfers++;
      if (bus.done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (cyc == 181) begin
        checks++;
        if (bus.busy_o !== 1'b1) begin
          errors++;
          $display("FAIL full_busy_done_state: busy %b want 1", bus.busy_o);
        end
      end
      if (cyc >= 182 && (bus.busy_o !== 1'b0 || bus.rd_en_o !== 1'b0)) idle_viol++;
      step();
    end
    bus.start_i = 1'b0;
    checks++;
    if (xfers != NPAIR) begin
      errors++;
      $display("FAIL full_xfers: got %0d want %0d", xfers, NPAIR);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 182) begin
      errors++;
      $display("FAIL full_done: got %0d pulses last at %0d want 1 at 182", done_cnt, done_cyc);
    end
    checks++;
    if (idle_viol != 0) begin
      errors++;
      $display("FAIL full_idle_after: got %0d busy/read cycles want 0", idle_viol);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL full_sb_leftover: got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_distinct();
    int want_c, want_b;
`ifdef TOUR_DISTINCT_PARENT_EN
    want_c = 17; want_b = 2;
`else
    want_c = 9;  want_b = 5;
`endif
    set_fit_linear();
    do_reset();
    rq = '{5, 12, 7, 5, 6, 7, 7, 5, 6, 30, 2, 23};
    start_round();
    while (!bus.pair_valid_o && cyc <= 40) step();
    checks++;
    if (cyc != want_c) begin
      errors++;
      $display("FAIL distinct_cycle: got %0d want %0d", cyc, want_c);
    end
    checks++;
    if (bus.parent_a_o !== 6'd5 || bus.parent_b_o !== IDX_W'(want_b)) begin
      errors++;
      $display("FAIL distinct_pair: got %0d/%0d want 5/%0d", bus.parent_a_o, bus.parent_b_o, want_b);
    end
    step();
  endtask

  initial begin
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.pair_ready_i = 1'b1;
    bus.rand_i = '0;
    test_reset();
    test_reset_mid();
    test_basic();
    test_tie();
    test_backpressure();
    test_full_round();
    test_distinct();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
